score_overlay: RTL and testbench

SCORE_OVERLAY -- requirements
Module: score_overlay

---
 rtl/score_overlay.sv | 206 ++++++++++++++++++++
 tb/tb_score_overlay.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/score_overlay.sv
// rtl/score_overlay.sv - converts both scores to BCD once per frame and overlays them as 7-segment digits.
// Optional per-player blink on score change is enabled by defining SCORE_FLASH_EN.
module score_overlay #(
  parameter int SCORE_X1 = 240,
  parameter int SCORE_X2 = 360,
  parameter int SCORE_Y  = 16,
  parameter int DIGIT_W  = 12,
  parameter int DIGIT_H  = 20,
  parameter int SEG_T    = 3
) (
  input  logic       clkin,
  input  logic       rst,
  input  logic       vsync,
  input  logic [9:0] hcount,
  input  logic [9:0] vcount,
  input  logic [7:0] player1_score,
  input  logic [7:0] player2_score,
  input  logic [3:0] red_in,
  input  logic [3:0] green_in,
  input  logic [3:0] blue_in,
  output logic [3:0] red,
  output logic [3:0] green,
  output logic [3:0] blue,
  output logic       busy
);

  localparam int PITCH = DIGIT_W + 4;
  localparam int G_TOP = (DIGIT_H - SEG_T) / 2;

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;

  state_t      state, state_nxt;
  logic        vsync_q;
  logic        fall;
  logic [2:0]  shift_cnt;
  // {bcd[11:0], remaining binary[7:0]}; binary MSB feeds the BCD LSB on each shift
  logic [19:0] conv1, conv2;
  logic [11:0] disp1, disp2;
  logic        en1, en2;
  logic        lit;
  int          px, py;

  function automatic logic [19:0] dd_step(input logic [19:0] v);
    logic [19:0] t;
    t = v;
    for (int i = 0; i < 3; i++)
      if (t[8+4*i +: 4] >= 4'd5) t[8+4*i +: 4] = t[8+4*i +: 4] + 4'd3;
    return {t[18:0], 1'b0};
  endfunction

  // Segment bits ordered {a,b,c,d,e,f,g}
  function automatic logic [6:0] seg_of(input logic [3:0] d);
    case (d)
      4'd0:    seg_of = 7'b1111110;
      4'd1:    seg_of = 7'b0110000;
      4'd2:    seg_of = 7'b1101101;
      4'd3:    seg_of = 7'b1111001;
      4'd4:    seg_of = 7'b0110011;
      4'd5:    seg_of = 7'b1011011;
      4'd6:    seg_of = 7'b1011111;
      4'd7:    seg_of = 7'b1110000;
      4'd8:    seg_of = 7'b1111111;
      4'd9:    seg_of = 7'b1111011;
      default: seg_of = 7'b0000000;
    endcase
  endfunction

  function automatic logic cell_lit(input int cx, input int cy, input int x0,
                                    input logic [3:0] d, input logic show);
    int x, y;
    logic [6:0] s;
    x = cx - x0;
    y = cy - SCORE_Y;
    s = seg_of(d);
    cell_lit = 1'b0;
    if (show && x >= 0 && x < DIGIT_W && y >= 0 && y < DIGIT_H)
      cell_lit = (s[6] && y < SEG_T) ||
                 (s[5] && x >= DIGIT_W - SEG_T && y < DIGIT_H / 2) ||
                 (s[4] && x >= DIGIT_W - SEG_T && y >= DIGIT_H / 2) ||
                 (s[3] && y >= DIGIT_H - SEG_T) ||
                 (s[2] && x < SEG_T && y >= DIGIT_H / 2) ||
                 (s[1] && x < SEG_T && y < DIGIT_H / 2) ||
                 (s[0] && y >= G_TOP && y < G_TOP + SEG_T);
  endfunction

  function automatic logic field_lit(input int cx, input int cy, input int x0,
                                     input logic [11:0] d, input logic en);
    logic nz_h, nz_t;
    nz_h = d[11:8] != 4'd0;
    nz_t = nz_h || d[7:4] != 4'd0;
    return cell_lit(cx, cy, x0,           d[11:8], en && nz_h) |
           cell_lit(cx, cy, x0 + PITCH,   d[7:4],  en && nz_t) |
           cell_lit(cx, cy, x0 + 2*PITCH, d[3:0],  en);
  endfunction

  assign fall = vsync_q & ~vsync;

  always_ff @(posedge clkin) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b1;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (fall) state_nxt = LOAD;
      end
      LOAD:  state_nxt = SHIFT;
      SHIFT: if (shift_cnt == 3'd7) state_nxt = DONE;
      DONE:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clkin) begin
    if (rst) begin
      vsync_q   <= 1'b1;
      shift_cnt <= 3'd0;
      conv1     <= 20'd0;
      conv2     <= 20'd0;
      disp1     <= 12'd0;
      disp2     <= 12'd0;
    end else begin
      vsync_q <= vsync;
      case (state)
        LOAD: begin
          conv1     <= {12'd0, player1_score};
          conv2     <= {12'd0, player2_score};
          shift_cnt <= 3'd0;
        end
        SHIFT: begin
          conv1     <= dd_step(conv1);
          conv2     <= dd_step(conv2);
          shift_cnt <= shift_cnt + 3'd1;
        end
        DONE: begin
          disp1 <= conv1[19:8];
          disp2 <= conv2[19:8];
        end
        default: ;
      endcase
    end
  end

`ifdef SCORE_FLASH_EN
  logic       blink1, blink2;
  logic [5:0] frame1, frame2;

  // A changed commit restarts the blink; otherwise each vsync fall advances it
  always_ff @(posedge clkin) begin
    if (rst) begin
      blink1 <= 1'b0;
      blink2 <= 1'b0;
      frame1 <= 6'd0;
      frame2 <= 6'd0;
    end else begin
      if (state == DONE && conv1[19:8] != disp1) begin
        blink1 <= 1'b1;
        frame1 <= 6'd0;
      end else if (fall && blink1) begin
        frame1 <= frame1 + 6'd1;
        if (frame1 == 6'd63) blink1 <= 1'b0;
      end
      if (state == DONE && conv2[19:8] != disp2) begin
        blink2 <= 1'b1;
        frame2 <= 6'd0;
      end else if (fall && blink2) begin
        frame2 <= frame2 + 6'd1;
        if (frame2 == 6'd63) blink2 <= 1'b0;
      end
    end
  end

  assign en1 = !(blink1 && !frame1[3]);
  assign en2 = !(blink2 && !frame2[3]);
`else
  assign en1 = 1'b1;
  assign en2 = 1'b1;
`endif

  always_comb begin
    px  = {22'd0, hcount};
    py  = {22'd0, vcount};
    lit = field_lit(px, py, SCORE_X1, disp1, en1) | field_lit(px, py, SCORE_X2, disp2, en2);
  end

  always_ff @(posedge clkin) begin
    if (rst) begin
      red   <= 4'h0;
      green <= 4'h0;
      blue  <= 4'h0;
    end else if (lit) begin
      red   <= 4'hF;
      green <= 4'hF;
      blue  <= 4'hF;
    end else begin
      red   <= red_in;
      green <= green_in;
      blue  <= blue_in;
    end
  end

endmodule

// File: tb/tb_score_overlay.sv
// tb/tb_score_overlay.sv - scoreboard bench for score_overlay pixel compositing and BCD conversion.
module tb_score_overlay;

  logic       clkin = 1'b0;
  logic       rst, vsync;
  logic [9:0] hcount, vcount;
  logic [7:0] player1_score, player2_score;
  logic [3:0] red_in, green_in, blue_in;
  logic [3:0] red, green, blue;
  logic       busy;

  score_overlay dut (
    .clkin(clkin), .rst(rst), .vsync(vsync), .hcount(hcount), .vcount(vcount),
    .player1_score(player1_score), .player2_score(player2_score),
    .red_in(red_in), .green_in(green_in), .blue_in(blue_in),
    .red(red), .green(green), .blue(blue), .busy(busy)
  );

  always #5 clkin = ~clkin;

  int          vectors = 0;
  int          miscompares = 0;
  logic [11:0] exp_q[$];
  string       name_q[$];
  logic        issue = 1'b0;
  logic        issue_d = 1'b0;
  string       mon_n;
  logic [11:0] mon_e;
  int          n;

  localparam logic [11:0] BG = 12'h359;

  task automatic chk(input string nm, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  always @(posedge clkin) issue_d <= issue;

  always @(negedge clkin) begin
    if (issue_d) begin
      if (exp_q.size() == 0) chk("sb_underflow", 1, 0);
      else begin
        mon_n = name_q.pop_front();
        mon_e = exp_q.pop_front();
        chk(mon_n, {red, green, blue}, mon_e);
      end
    end
  end

  task automatic probe(input string nm, input int h, input int v, input bit on, input logic [11:0] bg);
    @(posedge clkin); #1;
    hcount = h[9:0];
    vcount = v[9:0];
    {red_in, green_in, blue_in} = bg;
    issue = 1'b1;
    exp_q.push_back(on ? 12'hFFF : bg);
    name_q.push_back(nm);
    @(posedge clkin); #1;
    issue = 1'b0;
  endtask

  task automatic pulse(input int p2_at, output int cnt);
    @(posedge clkin); #1;
    vsync = 1'b0;
    cnt = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clkin);
      if (i == 1) vsync = 1'b1;
      if (busy) begin
        cnt++;
        if (cnt == p2_at) player2_score = 8'd7;
      end else if (cnt > 0) break;
    end
  endtask

  task automatic settle();
`ifdef SCORE_FLASH_EN
    int k;
    repeat (8) pulse(-1, k);
`endif
  endtask

  initial begin
    rst = 1'b1; vsync = 1'b1; hcount = 10'd0; vcount = 10'd0;
    player1_score = 8'd0; player2_score = 8'd0;
    {red_in, green_in, blue_in} = BG;
    repeat (3) @(posedge clkin);
    #1;
    chk("rst_red", red, 0);
    chk("rst_busy", busy, 0);
    rst = 1'b0;

    probe("s1_units_a", 278, 16, 1, BG);
    probe("s1_hund_blank", 246, 16, 0, BG);
    probe("s1_tens_blank", 262, 16, 0, BG);

    player1_score = 8'd255;
    pulse(3, n);
    chk("busy_len_255", n, 10);
    probe("p2_ignored_d", 398, 34, 1, BG);
    pulse(-1, n);
    chk("busy_len_7", n, 10);
    settle();

    probe("h2_a", 246, 16, 1, BG);
    probe("h2_f", 241, 20, 0, BG);
    probe("h2_e", 241, 30, 1, BG);
    probe("h2_c", 250, 30, 0, BG);
    probe("t5_b", 266, 20, 0, BG);
    probe("t5_f", 257, 20, 1, BG);
    probe("t5_c", 266, 30, 1, BG);
    probe("t5_e", 257, 30, 0, BG);
    probe("u5_g", 278, 25, 1, BG);
    probe("p2_u7_d", 398, 34, 0, 12'h0A5);
    probe("p2_u7_a", 398, 16, 1, BG);
    probe("p2_tens_blank", 382, 16, 0, BG);
    probe("p2_hund_blank", 366, 16, 0, BG);
    probe("red_pass", 100, 100, 0, 12'h3A1);

    player1_score = 8'd123;
    @(posedge clkin); #1 vsync = 1'b0;
    @(posedge clkin); #1 vsync = 1'b1;
    repeat (4) @(posedge clkin);
    #1;
    chk("mid_conv_busy", busy, 1);
    rst = 1'b1;
    @(posedge clkin); #1;
    rst = 1'b0;
    chk("abort_busy", busy, 0);
    probe("abort_u0_e", 273, 30, 1, BG);
    probe("abort_hund_blank", 246, 16, 0, BG);

    pulse(-1, n);
    chk("busy_len_123", n, 10);
    settle();
    probe("h1_a", 246, 16, 0, BG);
    probe("h1_b", 250, 20, 1, BG);
    probe("t2_e", 257, 30, 1, BG);
    probe("u3_e", 273, 30, 0, BG);
    probe("u3_g", 278, 25, 1, BG);

`ifdef SCORE_FLASH_EN
    player1_score = 8'd4;
    repeat (65) pulse(-1, n);
    player1_score = 8'd5;
    pulse(-1, n);
    probe("fl_f0_blank", 278, 16, 0, BG);
    probe("fl_p2_lit", 398, 16, 1, BG);
    repeat (7) pulse(-1, n);
    probe("fl_f7_blank", 278, 16, 0, BG);
    pulse(-1, n);
    probe("fl_f8_lit", 278, 16, 1, BG);
    repeat (56) pulse(-1, n);
    probe("fl_f64_lit", 278, 16, 1, BG);
`endif

    repeat (3) @(posedge clkin);
    chk("sb_drain", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
